// File: rtl/output_agc.sv
// output_agc: automatic gain control and hard limiter in front of the PWM stage.
// Each accepted sample is multiplied by a Q4.8 gain, floored back to integer,
// clamped to 16 bits and emitted with a one-cycle valid. Gain drops quickly on
// loud peaks and creeps back up after a run of quiet samples.
module output_agc #(
  parameter int TARGET          = 24000,
  parameter int ATTACK_SHIFT    = 4,
  parameter int RELEASE_SAMPLES = 4410,
  parameter int GAIN_MIN        = 32,
  parameter int GAIN_MAX        = 2048
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic signed [15:0] pcm_in,
  input  logic               pcm_valid,
  output logic signed [15:0] pcm_out,
  output logic               out_valid,
  output logic        [11:0] gain_out,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, MULT, SAT, UPD} state_t;

  localparam logic signed [20:0] TGT_POS    = 21'(TARGET);
  localparam logic signed [20:0] TGT_NEG    = -TGT_POS;
  localparam logic signed [20:0] SAT_POS    = 21'sd32767;
  localparam logic signed [20:0] SAT_NEG    = -21'sd32768;
  localparam logic        [11:0] GAIN_UNITY = 12'd256;
  localparam logic        [11:0] G_MIN      = 12'(GAIN_MIN);
  localparam logic        [11:0] G_MAX      = 12'(GAIN_MAX);
  localparam logic        [15:0] HOLD_LIM   = 16'(RELEASE_SAMPLES);

  state_t state, state_next;

  logic signed [15:0] x;
  logic               en_q;
  logic signed [28:0] prod;
  logic        [11:0] gain;
  logic        [15:0] hold_cnt;
  logic               loud;

  logic signed [12:0] g_eff;
  logic signed [28:0] mult;
  logic signed [20:0] y;
  logic signed [15:0] pcm_sat;
  logic               loud_next;
  logic        [11:0] attack_step;
  logic        [11:0] gain_dec;
  logic        [11:0] gain_inc;

  // Bypass uses exact unity gain so a disabled sample passes through untouched.
  assign g_eff = en_q ? $signed({1'b0, gain}) : $signed({1'b0, GAIN_UNITY});
  assign mult  = 29'(x) * 29'(g_eff);
  // Arithmetic shift floors toward minus infinity, matching the Q4.8 scaling.
  assign y     = 21'(prod >>> 8);

  assign pcm_sat   = (y > SAT_POS) ? 16'sh7FFF :
                     (y < SAT_NEG) ? 16'sh8000 : y[15:0];
  // Loudness is judged before clamping so heavy overdrive still pulls gain down.
  assign loud_next = (y > TGT_POS) || (y < TGT_NEG);

  assign attack_step = (gain >> ATTACK_SHIFT) + 12'd1;
  assign gain_dec    = ({1'b0, gain} < ({1'b0, G_MIN} + {1'b0, attack_step}))
                       ? G_MIN : (gain - attack_step);
  assign gain_inc    = (gain >= G_MAX) ? G_MAX : (gain + 12'd1);

  assign gain_out = gain;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Fixed four-step walk per sample: capture, multiply, saturate, update gain.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pcm_valid) state_next = MULT;
      MULT:    state_next = SAT;
      SAT:     state_next = UPD;
      UPD:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, output registers and gain/hold bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      en_q      <= 1'b0;
      prod      <= '0;
      pcm_out   <= '0;
      out_valid <= 1'b0;
      loud      <= 1'b0;
      gain      <= GAIN_UNITY;
      hold_cnt  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (pcm_valid && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (pcm_valid) begin
            x    <= pcm_in;
            en_q <= enable;
          end
        end
        MULT: prod <= mult;
        SAT: begin
          pcm_out   <= pcm_sat;
          out_valid <= 1'b1;
          loud      <= loud_next;
        end
        UPD: begin
          out_valid <= 1'b0;
          if (en_q) begin
            if (loud) begin
              gain     <= gain_dec;
              hold_cnt <= '0;
            end else if (hold_cnt == HOLD_LIM) begin
              gain <= gain_inc;
            end else begin
              hold_cnt <= hold_cnt + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_agc.sv
// tb_output_agc: directed vectors with hand-computed expectations for output_agc.
// Two instances share the stimulus: dut_a (release after 8 quiet samples) and
// dut_b (release after 1, used to drive the gain to its ceiling quickly).
`timescale 1ns/1ps
module tb_output_agc;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [15:0] pcm_in;
  logic               pcm_valid;

  logic signed [15:0] pcm_out_a, pcm_out_b;
  logic               out_valid_a, out_valid_b;
  logic        [11:0] gain_out_a, gain_out_b;
  logic               overrun_a, overrun_b;

  bit                 use_b = 1'b0;
  logic signed [15:0] pcm_out_s;
  logic               out_valid_s;
  logic        [11:0] gain_out_s;
  logic               overrun_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  output_agc #(.RELEASE_SAMPLES(8)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .pcm_in(pcm_in), .pcm_valid(pcm_valid),
    .pcm_out(pcm_out_a), .out_valid(out_valid_a), .gain_out(gain_out_a), .overrun(overrun_a)
  );

  output_agc #(.RELEASE_SAMPLES(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .pcm_in(pcm_in), .pcm_valid(pcm_valid),
    .pcm_out(pcm_out_b), .out_valid(out_valid_b), .gain_out(gain_out_b), .overrun(overrun_b)
  );

  assign pcm_out_s   = use_b ? pcm_out_b   : pcm_out_a;
  assign out_valid_s = use_b ? out_valid_b : out_valid_a;
  assign gain_out_s  = use_b ? gain_out_b  : gain_out_a;
  assign overrun_s   = use_b ? overrun_b   : overrun_a;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    pcm_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one sample at minimum spacing; returns at the negedge after edge N+3.
  task automatic runSample(input logic signed [15:0] val, input logic en, input bit toggle,
                           output int v_early, output int v_mid, output int v_late,
                           output int out_obs, output int gain_obs);
    pcm_in    = val;
    enable    = en;
    pcm_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pcm_valid = 1'b0;
    if (toggle) enable = ~en;
    v_early = int'(out_valid_s);
    @(negedge clk);
    v_early = v_early | int'(out_valid_s);
    @(negedge clk);
    v_mid   = int'(out_valid_s);
    out_obs = int'(pcm_out_s);
    @(negedge clk);
    v_late   = int'(out_valid_s);
    gain_obs = int'(gain_out_s);
  endtask

  task automatic applyStimulus(input string tag, input logic signed [15:0] val, input logic en,
                               input bit toggle, input int exp_out, input int exp_gain);
    int ve, vm, vl, o, g;
    runSample(val, en, toggle, ve, vm, vl, o, g);
    checkOutput({tag, "_valid_early"}, ve, 0);
    checkOutput({tag, "_valid"}, vm, 1);
    checkOutput({tag, "_valid_late"}, vl, 0);
    checkOutput({tag, "_pcm_out"}, o, exp_out);
    checkOutput({tag, "_gain"}, g, exp_gain);
  endtask

  // Feeds quiet samples to dut_b until its gain reaches the ceiling or the budget runs out.
  task automatic forceGainMax(input string tag, input int budget);
    int ve, vm, vl, o, g;
    g = 0;
    for (int i = 0; i < budget && g != 2048; i++)
      runSample(16'sd0, 1'b1, 1'b0, ve, vm, vl, o, g);
    checkOutput(tag, g, 2048);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int g;
    rst = 1'b1; enable = 1'b0; pcm_in = '0; pcm_valid = 1'b0;

    // Reset values.
    resetDut();
    checkOutput("rst_pcm_out", int'(pcm_out_a), 0);
    checkOutput("rst_out_valid", int'(out_valid_a), 0);
    checkOutput("rst_overrun", int'(overrun_a), 0);
    checkOutput("rst_gain_a", int'(gain_out_a), 256);
    checkOutput("rst_gain_b", int'(gain_out_b), 256);

    // Unity pass-through, then two attacks: 256-17=239, floor(30000*239/256)=28007, 239-15=224.
    applyStimulus("s1000", 16'sd1000, 1'b1, 1'b0, 1000, 256);
    applyStimulus("loud1", 16'sd30000, 1'b1, 1'b0, 30000, 239);
    applyStimulus("loud2", 16'sd30000, 1'b1, 1'b0, 28007, 224);

    // Full-scale inputs at unity gain pass exactly; both are loud.
    resetDut();
    applyStimulus("neg_full", -16'sd32768, 1'b1, 1'b0, -32768, 239);
    resetDut();
    applyStimulus("pos_full", 16'sd32767, 1'b1, 1'b0, 32767, 239);

    // Bypass and release with RELEASE_SAMPLES=8.
    resetDut();
    applyStimulus("attack", 16'sd30000, 1'b1, 1'b0, 30000, 239);
    applyStimulus("bypass", 16'sd30000, 1'b0, 1'b0, 30000, 239);
    applyStimulus("en_toggle", 16'sd30000, 1'b0, 1'b1, 30000, 239);
    for (int i = 0; i < 8; i++)
      applyStimulus($sformatf("hold%0d", i), 16'sd100, 1'b1, 1'b0, 93, 239);
    g = 239;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus($sformatf("release%0d", k), 16'sd100, 1'b1, 1'b0, (100 * g) / 256, g + 1);
      g = g + 1;
    end

    // Gain ceiling and saturation on dut_b.
    use_b = 1'b1;
    resetDut();
    forceGainMax("force_2048", 2000);
    applyStimulus("gain_ceiling", 16'sd0, 1'b1, 1'b0, 0, 2048);
    applyStimulus("sat_pos", 16'sd20000, 1'b1, 1'b0, 32767, 1919);
    forceGainMax("reforce_2048", 300);
    applyStimulus("sat_neg", -16'sd20000, 1'b1, 1'b0, -32768, 1919);
    use_b = 1'b0;

    // Overrun: second valid two edges after the first is ignored.
    resetDut();
    cnt = 0;
    pcm_in = 16'sd1000; enable = 1'b1; pcm_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pcm_valid = 1'b0;
    cnt += int'(out_valid_a);
    @(posedge clk);
    @(negedge clk);
    cnt += int'(out_valid_a);
    checkOutput("ovr_before", int'(overrun_a), 0);
    pcm_in = 16'sd5000; pcm_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pcm_valid = 1'b0;
    cnt += int'(out_valid_a);
    checkOutput("ovr_set", int'(overrun_a), 1);
    checkOutput("ovr_pcm_out", int'(pcm_out_a), 1000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cnt += int'(out_valid_a);
    end
    checkOutput("ovr_valid_count", cnt, 1);
    checkOutput("ovr_sticky", int'(overrun_a), 1);
    checkOutput("ovr_pcm_hold", int'(pcm_out_a), 1000);
    resetDut();
    checkOutput("ovr_cleared", int'(overrun_a), 0);

    // Reset one edge after capture discards the sample.
    applyStimulus("pre_rst", 16'sd30000, 1'b1, 1'b0, 30000, 239);
    cnt = 0;
    pcm_in = 16'sd5000; enable = 1'b1; pcm_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pcm_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cnt += int'(out_valid_a);
      @(negedge clk);
    end
    checkOutput("rst_mid_valid_count", cnt, 0);
    checkOutput("rst_mid_pcm_out", int'(pcm_out_a), 0);
    checkOutput("rst_mid_gain", int'(gain_out_a), 256);
    checkOutput("rst_mid_overrun", int'(overrun_a), 0);
    applyStimulus("post_rst", 16'sd1000, 1'b1, 1'b0, 1000, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
